// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave bank.
//   apb_state_e      : per-transfer FSM encoding (IDLE / SETUP / ACCESS)
//   WAIT_CYCLES_MAX  : largest supported wait-state count
//   WAIT_CNT_W       : width of the wait-state counter
//   clog2()          : constant-evaluable ceiling log2 for index widths
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int WAIT_CYCLES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// One APB slave's word-addressed register file.
//   clk, rst_n : clock and asynchronous active-low reset (all words -> RESET_VAL)
//   we         : commit wdata into word waddr at the rising edge
//   waddr      : word index of the write
//   wdata      : write data
//   raddr      : word index of the combinational read port
//   rdata      : contents of word raddr
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  localparam int                   IDX_W      = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_bank.sv
// APB slave bank: NUM_SLAVES register-file slaves behind one transfer FSM.
//   Hclk, Hresetn : clock, asynchronous active-low reset
//   Pselx         : one-hot slave select
//   Penable       : APB enable
//   Pwrite        : 1 = write, 0 = read
//   Paddr         : byte address, word index = Paddr[2 +: log2(DEPTH)]
//   Pwdata        : write data
//   Prdata        : read data, non-zero only on a completing good read
//   Pready        : transfer completes this cycle
//   Pslverr       : completing transfer is in error (qualified by Pready)
// Build option: APB_WAIT_STATES_EN enables the WAIT_CYCLES wait-state counter;
// without it every ACCESS cycle completes immediately.
module apb_slave_bank
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES  = 3,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W = clog2(DEPTH);

  function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - NUM_SLAVES'(1))) == '0);
  endfunction

  apb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_p1;
  logic                  pwrite_p1, err_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic [DATA_WIDTH-1:0] wdata_p1, rd_p1;

  logic                  setup_req, err_c, pready_c, bank_we;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] rdata_s [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_addr_lsb;

  // byte lanes are not supported; the two low address bits carry no meaning
  assign unused_addr_lsb = ^Paddr[1:0];

  assign setup_req = (|Pselx) && !Penable;
  assign idx_c     = Paddr[2 +: IDX_W];
  assign err_c     = !is_onehot(Pselx) || (Paddr[ADDR_WIDTH-1:2+IDX_W] != '0);

`ifdef APB_WAIT_STATES_EN
  logic [WAIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= WAIT_CNT_W'(WAIT_CYCLES);
    end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WAIT_CNT_W'(1);
    end
  end

  assign pready_c = (state_q == ST_ACCESS) && (cnt_q == '0);
`else
  assign pready_c = (state_q == ST_ACCESS);
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A completing ACCESS may chain straight into the next SETUP; an ACCESS
  // still waiting is abandoned as soon as the master drops every select.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (setup_req) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_c)            state_d = setup_req ? ST_SETUP : ST_IDLE;
        else if (Pselx == '0)    state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (Pselx[i]) rd_mux = rd_mux | rdata_s[i];
    end
  end

  // ---- stage p1: SETUP capture (control with reset, data without) ----
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      psel_p1   <= '0;
      pwrite_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else if (state_q == ST_SETUP) begin
      psel_p1   <= Pselx;
      pwrite_p1 <= Pwrite;
      err_p1    <= err_c;
    end
  end

  always_ff @(posedge Hclk) begin
    if (state_q == ST_SETUP) begin
      idx_p1   <= idx_c;
      wdata_p1 <= Pwdata;
      rd_p1    <= err_c ? '0 : rd_mux;
    end
  end

  // ---- ACCESS completion: write commit and response ----
  assign bank_we = pready_c && pwrite_p1 && !err_p1;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    apb_slave_regfile #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .RESET_VAL (RESET_VAL)
    ) u_regfile (
      .clk  (Hclk),
      .rst_n(Hresetn),
      .we   (bank_we && psel_p1[g]),
      .waddr(idx_p1),
      .wdata(wdata_p1),
      .raddr(idx_c),
      .rdata(rdata_s[g])
    );
  end

  assign Pready  = pready_c;
  assign Pslverr = pready_c && err_p1;
  assign Prdata  = (pready_c && !pwrite_p1 && !err_p1) ? rd_p1 : '0;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank. Two instances: d0 with WAIT_CYCLES=0,
// d1 with WAIT_CYCLES=3 (wait states only take effect with APB_WAIT_STATES_EN).
module tb_apb_slave_bank;

  localparam logic [31:0] RV0 = 32'hA5A5_0000;
  localparam logic [31:0] RV1 = 32'h1234_5678;
`ifdef APB_WAIT_STATES_EN
  localparam int WEXP = 3;
`else
  localparam int WEXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr[2];

  int          checks   = 0;
  int          failures = 0;
  int          cyc;
  logic [31:0] rdv;
  logic        errv;
  logic        seen;

  always #5 clk = ~clk;

  apb_slave_bank #(.WAIT_CYCLES(0), .RESET_VAL(RV0)) u_dut0 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel[0]), .Penable(pen[0]), .Pwrite(pwr[0]),
    .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Prdata(prdata[0]), .Pready(pready[0]),
    .Pslverr(pslverr[0]));

  apb_slave_bank #(.WAIT_CYCLES(3), .RESET_VAL(RV1)) u_dut1 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel[1]), .Penable(pen[1]), .Pwrite(pwr[1]),
    .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Prdata(prdata[1]), .Pready(pready[1]),
    .Pslverr(pslverr[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transfer; cyc = SETUP cycle + ACCESS cycles up to Pready.
  task automatic xfer(input int d, input logic [2:0] sel, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wd,
                      output int c, output logic [31:0] rd, output logic er);
    int   n;
    logic done;
    @(posedge clk); #1;
    psel[d] = sel; pen[d] = 1'b0; paddr[d] = addr; pwr[d] = wr; pwdata[d] = wd;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    n = 0; done = 1'b0; rd = '0; er = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1; rd = prdata[d]; er = pslverr[d];
      end
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    c = n + 1;
    @(posedge clk); #1;
    psel[d] = '0; pen[d] = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int d, input logic [2:0] sel,
                        input logic [31:0] addr, input logic [31:0] exp);
    int          c;
    logic [31:0] r;
    logic        e;
    xfer(d, sel, addr, 1'b0, 32'h0, c, r, e);
    chk(tag, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = '0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", {31'd0, pready[0]}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset word values
    rd_chk("rst_val_d0", 0, 3'b010, 32'h3C, RV0);
    rd_chk("rst_val_d1", 1, 3'b100, 32'h20, RV1);

    // reset asserted mid-SETUP drops the write and restores the word
    xfer(0, 3'b001, 32'hC, 1'b1, 32'h0000_1111, cyc, rdv, errv);
    rd_chk("pre_rst_word", 0, 3'b001, 32'hC, 32'h0000_1111);
    @(posedge clk); #1;
    psel[0] = 3'b001; pen[0] = 1'b0; paddr[0] = 32'hC; pwr[0] = 1'b1; pwdata[0] = 32'h2222;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, pready[0]}, 32'd0);
    chk("midrst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("midrst_prdata", prdata[0], 32'd0);
    psel[0] = '0; pen[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_chk("midrst_word", 0, 3'b001, 32'hC, RV0);

    // basic write / read, zero wait states
    xfer(0, 3'b010, 32'h8, 1'b1, 32'hDEAD_BEEF, cyc, rdv, errv);
    chk("wr_cycles", cyc, 2);
    chk("wr_err", {31'd0, errv}, 32'd0);
    chk("wr_prdata0", rdv, 32'd0);
    xfer(0, 3'b010, 32'h8, 1'b0, 32'h0, cyc, rdv, errv);
    chk("rd_cycles", cyc, 2);
    chk("rd_data", rdv, 32'hDEAD_BEEF);
    rd_chk("s0_unchanged", 0, 3'b001, 32'h8, RV0);
    rd_chk("s2_unchanged", 0, 3'b100, 32'h8, RV0);

    // wait states on d1
    xfer(1, 3'b100, 32'h0, 1'b0, 32'h0, cyc, rdv, errv);
    chk("wait_rd_cycles", cyc, WEXP + 2);
    chk("wait_rd_data", rdv, RV1);
    xfer(1, 3'b010, 32'h8, 1'b1, 32'hCAFE_F00D, cyc, rdv, errv);
    chk("wait_wr_cycles", cyc, WEXP + 2);
    rd_chk("wait_rdback", 1, 3'b010, 32'h8, 32'hCAFE_F00D);

    // errors
    xfer(0, 3'b010, 32'h40, 1'b1, 32'h0000_0BAD, cyc, rdv, errv);
    chk("err_addr_wr", {31'd0, errv}, 32'd1);
    chk("err_addr_cycles", cyc, 2);
    rd_chk("err_addr_nowrite", 0, 3'b010, 32'h0, RV0);
    xfer(0, 3'b010, 32'h48, 1'b0, 32'h0, cyc, rdv, errv);
    chk("err_addr_rd", {31'd0, errv}, 32'd1);
    chk("err_rd_prdata0", rdv, 32'd0);
    xfer(0, 3'b011, 32'h10, 1'b1, 32'h7777_7777, cyc, rdv, errv);
    chk("err_sel_wr", {31'd0, errv}, 32'd1);
    rd_chk("err_sel_s0", 0, 3'b001, 32'h10, RV0);
    rd_chk("err_sel_s1", 0, 3'b010, 32'h10, RV0);
    xfer(0, 3'b001, 32'h10, 1'b0, 32'h0, cyc, rdv, errv);
    chk("good_rd_noerr", {31'd0, errv}, 32'd0);

    // back-to-back: write slave0 then read slave2 with no idle cycle
    xfer(0, 3'b100, 32'h4, 1'b1, 32'h0BAD_F00D, cyc, rdv, errv);
    @(posedge clk); #1;
    psel[0] = 3'b001; pen[0] = 1'b0; paddr[0] = 32'h4; pwr[0] = 1'b1; pwdata[0] = 32'h1357_9BDF;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    @(posedge clk); #1;
    psel[0] = 3'b100; pen[0] = 1'b0; pwr[0] = 1'b0; pwdata[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("b2b_wr_rdy", {31'd0, pready[0]}, 32'd1);
    chk("b2b_wr_err", {31'd0, pslverr[0]}, 32'd0);
    @(posedge clk); #1;
    pen[0] = 1'b1;
    @(negedge clk);
    chk("b2b_setup_rdy", {31'd0, pready[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rd_rdy", {31'd0, pready[0]}, 32'd1);
    chk("b2b_rd_data", prdata[0], 32'h0BAD_F00D);
    @(posedge clk); #1;
    psel[0] = '0; pen[0] = 1'b0;
    rd_chk("b2b_wr_word", 0, 3'b001, 32'h4, 32'h1357_9BDF);

`ifdef APB_WAIT_STATES_EN
    // abort: select dropped during wait states
    @(posedge clk); #1;
    psel[1] = 3'b001; pen[1] = 1'b0; paddr[1] = 32'h14; pwr[1] = 1'b1; pwdata[1] = 32'h5555_AAAA;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rdy_first", {31'd0, pready[1]}, 32'd0);
    @(posedge clk); #1;
    psel[1] = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[1]) seen = 1'b1;
    end
    chk("abort_no_rdy", {31'd0, seen}, 32'd0);
    pen[1] = 1'b0;
    rd_chk("abort_nowrite", 1, 3'b001, 32'h14, RV1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
